// File: rtl/updown_counter.sv
// Up/down counter with runtime upper bound, saturate-or-wrap mode, load and bound/wrap flags.
// Optional sticky overflow flag enabled by defining UPDOWN_COUNTER_STICKY_EN.
module updown_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             satEn,
  input  logic [WIDTH-1:0] limit,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] output_data,
  output logic             tc,
  output logic             at_bound,
  output logic             ovf_sticky
);

  localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] ONE_X  = (WIDTH+1)'(1);

  logic [WIDTH-1:0] r_q;
  logic             r_tc;
  logic             r_at_bound;

  logic [WIDTH:0]   w_q_x;
  logic [WIDTH:0]   w_lim_x;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_wrap_up;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_dn_base;
  logic [WIDTH:0]   w_wrap_dn;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_tc_nxt;
  logic             w_bound_nxt;
  logic             w_clamp;

  always_comb begin
    w_q_x       = {1'b0, r_q};
    w_lim_x     = {1'b0, limit};
    w_sum       = w_q_x + STEP_X;
    w_wrap_up   = w_sum - w_lim_x - ONE_X;
    w_diff      = w_q_x - STEP_X;
    w_dn_base   = w_lim_x + ONE_X + w_q_x;
    w_wrap_dn   = w_dn_base - STEP_X;
    w_q_nxt     = r_q;
    w_tc_nxt    = 1'b0;
    w_bound_nxt = r_at_bound;
    w_clamp     = 1'b0;

    if (load) begin
      w_q_nxt     = (load_data > limit) ? limit : load_data;
      w_bound_nxt = 1'b0;
    end else if (en) begin
      if (up) begin
        if (w_q_x > w_lim_x) begin
          // Count already above a lowered limit: treat as out of range.
          if (satEn) begin
            w_q_nxt = limit;
            w_clamp = 1'b1;
          end else begin
            w_q_nxt  = '0;
            w_tc_nxt = 1'b1;
          end
        end else if (w_sum <= w_lim_x) begin
          w_q_nxt = w_sum[WIDTH-1:0];
        end else if (satEn) begin
          w_q_nxt = limit;
          w_clamp = 1'b1;
        end else begin
          // A step larger than the whole range folds to 0 rather than leaving the range.
          w_q_nxt  = (w_wrap_up > w_lim_x) ? '0 : w_wrap_up[WIDTH-1:0];
          w_tc_nxt = 1'b1;
        end
      end else begin
        if (w_q_x >= STEP_X) begin
          w_q_nxt = w_diff[WIDTH-1:0];
        end else if (satEn) begin
          w_q_nxt = '0;
          w_clamp = 1'b1;
        end else begin
          w_q_nxt  = (w_dn_base < STEP_X) ? '0 : w_wrap_dn[WIDTH-1:0];
          w_tc_nxt = 1'b1;
        end
      end
      w_bound_nxt = w_clamp;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q        <= '0;
      r_tc       <= 1'b0;
      r_at_bound <= 1'b0;
    end else begin
      r_q        <= w_q_nxt;
      r_tc       <= w_tc_nxt;
      r_at_bound <= w_bound_nxt;
    end
  end

`ifdef UPDOWN_COUNTER_STICKY_EN
  logic r_sticky;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sticky <= 1'b0;
    end else if (load) begin
      r_sticky <= 1'b0;
    end else if (w_tc_nxt || w_clamp) begin
      r_sticky <= 1'b1;
    end
  end

  assign ovf_sticky = r_sticky;
`else
  assign ovf_sticky = 1'b0;
`endif

  assign output_data = r_q;
  assign tc          = r_tc;
  assign at_bound    = r_at_bound;

endmodule

// File: tb/tb_updown_counter.sv
// Scoreboard bench for updown_counter: the driver queues the expected {count,tc,at_bound,sticky}
// per driven cycle; a monitor pops and compares after every rising edge.
module tb_updown_counter;

`ifdef UPDOWN_COUNTER_STICKY_EN
  localparam logic STK = 1'b1;
`else
  localparam logic STK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  logic       a_en = 0, a_up = 0, a_sat = 0, a_load = 0;
  logic [3:0] a_lim = '0, a_ld = '0;
  logic [3:0] a_q;
  logic       a_tc, a_b, a_s;

  logic       b_en = 0, b_up = 0, b_sat = 0, b_load = 0;
  logic [3:0] b_lim = '0, b_ld = '0;
  logic [3:0] b_q;
  logic       b_tc, b_b, b_s;

  logic [6:0] qa[$];
  logic [6:0] qb[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  updown_counter #(.WIDTH(4), .STEP(1)) u_dut_a (
    .clk(clk), .reset(reset), .en(a_en), .up(a_up), .satEn(a_sat), .limit(a_lim),
    .load(a_load), .load_data(a_ld), .output_data(a_q), .tc(a_tc), .at_bound(a_b),
    .ovf_sticky(a_s)
  );

  updown_counter #(.WIDTH(4), .STEP(3)) u_dut_b (
    .clk(clk), .reset(reset), .en(b_en), .up(b_up), .satEn(b_sat), .limit(b_lim),
    .load(b_load), .load_data(b_ld), .output_data(b_q), .tc(b_tc), .at_bound(b_b),
    .ovf_sticky(b_s)
  );

  function automatic void check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got q=%0d tc=%b bound=%b sticky=%b, expected q=%0d tc=%b bound=%b sticky=%b",
               name, act[6:3], act[2], act[1], act[0], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endfunction

  task automatic stepa(input logic ien, iup, isat, input logic [3:0] ilim,
                       input logic ild, input logic [3:0] ild_d,
                       input logic [3:0] eq, input logic etc, eb, es);
    @(negedge clk);
    a_en = ien; a_up = iup; a_sat = isat; a_lim = ilim; a_load = ild; a_ld = ild_d;
    qa.push_back({eq, etc, eb, es & STK});
  endtask

  task automatic stepb(input logic ien, iup, isat, input logic [3:0] ilim,
                       input logic [3:0] eq, input logic etc, eb, es);
    @(negedge clk);
    b_en = ien; b_up = iup; b_sat = isat; b_lim = ilim; b_load = 1'b0; b_ld = '0;
    qb.push_back({eq, etc, eb, es & STK});
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) check("dutA_cycle", {a_q, a_tc, a_b, a_s}, qa.pop_front());
      if (qb.size() > 0) check("dutB_cycle", {b_q, b_tc, b_b, b_s}, qb.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #2;
    check("reset_A", {a_q, a_tc, a_b, a_s}, 7'b0);
    check("reset_B", {b_q, b_tc, b_b, b_s}, 7'b0);
    @(negedge clk);
    reset = 1'b0;

    // STEP=3, limit=9: 3,6,9,2(tc),5 then down 2,9(tc)
    stepb(1, 1, 0, 9, 4'd3, 0, 0, 0);
    stepb(1, 1, 0, 9, 4'd6, 0, 0, 0);
    stepb(1, 1, 0, 9, 4'd9, 0, 0, 0);
    stepb(1, 1, 0, 9, 4'd2, 1, 0, 1);
    stepb(1, 1, 0, 9, 4'd5, 0, 0, 1);
    stepb(1, 0, 0, 9, 4'd2, 0, 0, 1);
    stepb(1, 0, 0, 9, 4'd9, 1, 0, 1);
    stepb(0, 0, 0, 9, 4'd9, 0, 0, 1);
    @(negedge clk);
    b_en = 1'b0;

    // Wrap count 1..15, 0 (tc), 1
    for (int i = 1; i <= 17; i++)
      stepa(1, 1, 0, 15, 0, 0, 4'(i % 16), (i == 16), 0, (i >= 16));

    // Load clears sticky; saturating up-count sticks at 15
    stepa(0, 0, 0, 15, 1, 0, 4'd0, 0, 0, 0);
    for (int i = 1; i <= 20; i++)
      stepa(1, 1, 1, 15, 0, 0, 4'((i > 15) ? 15 : i), 0, (i > 15), (i > 15));
    stepa(0, 1, 1, 15, 0, 0, 4'd15, 0, 1, 1);

    // Load wins over enable and is clipped to limit; then saturate down to 0
    stepa(1, 1, 1, 10, 1, 12, 4'd10, 0, 0, 0);
    for (int i = 9; i >= 0; i--)
      stepa(1, 0, 1, 10, 0, 0, 4'(i), 0, 0, 0);
    stepa(1, 0, 1, 10, 0, 0, 4'd0, 0, 1, 1);
    stepa(1, 0, 1, 10, 0, 0, 4'd0, 0, 1, 1);

    // Limit lowered below the current count
    stepa(0, 0, 0, 15, 1, 14, 4'd14, 0, 0, 0);
    stepa(1, 1, 1, 10, 0, 0, 4'd10, 0, 1, 1);
    stepa(0, 0, 0, 15, 1, 14, 4'd14, 0, 0, 0);
    stepa(1, 1, 0, 10, 0, 0, 4'd0, 1, 0, 1);
    stepa(0, 0, 0, 15, 1, 14, 4'd14, 0, 0, 0);
    stepa(1, 0, 0, 10, 0, 0, 4'd13, 0, 0, 0);

    // limit = 0 pins the count at 0
    stepa(0, 0, 0, 0, 1, 5, 4'd0, 0, 0, 0);
    stepa(1, 1, 0, 0, 0, 0, 4'd0, 1, 0, 1);
    stepa(1, 1, 0, 0, 0, 0, 4'd0, 1, 0, 1);
    stepa(1, 1, 1, 0, 0, 0, 4'd0, 0, 1, 1);
    stepa(1, 0, 1, 0, 0, 0, 4'd0, 0, 1, 1);
    stepa(1, 0, 0, 0, 0, 0, 4'd0, 1, 0, 1);

    // satEn change acts on the same edge
    stepa(0, 0, 0, 15, 1, 15, 4'd15, 0, 0, 0);
    stepa(1, 1, 1, 15, 0, 0, 4'd15, 0, 1, 1);
    stepa(1, 1, 0, 15, 0, 0, 4'd0, 1, 0, 1);

    // Reach 7 via a down-wrap (sets sticky), then reset asynchronously mid-cycle
    stepa(0, 0, 0, 7, 1, 0, 4'd0, 0, 0, 0);
    stepa(1, 0, 0, 7, 0, 0, 4'd7, 1, 0, 1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_A", {a_q, a_tc, a_b, a_s}, 7'b0);
    check("async_reset_B", {b_q, b_tc, b_b, b_s}, 7'b0);
    @(negedge clk);
    reset = 1'b0;
    a_en = 1; a_up = 1; a_sat = 0; a_lim = 15; a_load = 0; a_ld = '0;
    qa.push_back({4'd1, 3'b000});
    stepa(0, 0, 0, 15, 0, 0, 4'd1, 0, 0, 0);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d entries left, expected 0/0", qa.size(), qb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
